// File: rtl/perf_pkg.sv
// Shared register map, CTRL bit positions and counter-address decode for the
// performance counter bank.
package perf_pkg;

  localparam logic [31:0] CTRL_OFF    = 32'h00;
  localparam logic [31:0] INHIBIT_OFF = 32'h04;
  localparam logic [31:0] OVF_OFF     = 32'h08;
  localparam logic [31:0] IRQ_EN_OFF  = 32'h0C;
  localparam logic [31:0] CNT_BASE    = 32'h10;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef struct packed {
    logic       is_lo;
    logic       is_hi;
    logic [4:0] index;
  } cnt_dec_t;

  // Counters occupy 8-byte pairs from CNT_BASE; anything past the last pair is unmapped.
  function automatic cnt_dec_t cnt_decode(input logic [31:0] addr,
                                          input int unsigned num_cnt);
    cnt_dec_t    d;
    logic [31:0] off;
    d   = '0;
    off = '0;
    if (addr >= CNT_BASE) begin
      off = (addr - CNT_BASE) >> 3;
      if (off < num_cnt) begin
        d.index = off[4:0];
        d.is_hi = addr[2];
        d.is_lo = ~addr[2];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/perf_cnt_slice.sv
// One CNT_W event counter with clear, split 32-bit writes and a wrap pulse.
module perf_cnt_slice #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic             clr,
  input  logic [31:0]      wdata,
  output logic             ovf_pulse,
  output logic [CNT_W-1:0] value
);

  // Clear beats a write, a write beats an increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      value <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) value[31:0]       <= wdata;
      if (wr_hi) value[CNT_W-1:32] <= wdata[CNT_W-33:0];
    end else if (inc) begin
      value <= value + 1'b1;
    end
  end

  assign ovf_pulse = inc & ~wr_lo & ~wr_hi & ~clr & (&value);

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters behind a 32-bit MMIO port, with sticky
// overflow flags, a level overflow interrupt and a tear-free LO/HI read shadow.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CNT = 8,
  parameter int CNT_W   = 64,
  parameter int ADDR_W  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_CNT-1:0] evt_i,
  input  logic               halt_i,
  input  logic               req_valid_i,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [31:0]        req_wdata_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               irq_o
);

  localparam int HI_W = CNT_W - 32;

  logic               en;
  logic [NUM_CNT-1:0] inhibit;
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] irq_en;
  logic [HI_W-1:0]    shadow;

  logic [31:0]        addr_w;
  logic               rd, wr, clr_all;
  cnt_dec_t           dec;
  logic [NUM_CNT-1:0] inc, ovf_pulse, ovf_w1c;
  logic [CNT_W-1:0]   cnt_val [NUM_CNT];
  logic [CNT_W-1:0]   sel_val;
  logic [31:0]        rd_data;

  assign addr_w  = 32'(req_addr_i) & ~32'h3;
  assign rd      = req_valid_i & ~req_we_i;
  assign wr      = req_valid_i & req_we_i;
  assign dec     = cnt_decode(addr_w, NUM_CNT);
  assign clr_all = wr & (addr_w == CTRL_OFF) & req_wdata_i[CTRL_CLR_BIT];
  assign ovf_w1c = (wr && addr_w == OVF_OFF) ? req_wdata_i[NUM_CNT-1:0] : '0;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic hit;
    assign hit    = wr & (dec.index == 5'(i));
    assign inc[i] = en & ~inhibit[i] & ~halt_i & evt_i[i];

    perf_cnt_slice #(.CNT_W(CNT_W)) u_slice (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc       (inc[i]),
      .wr_lo     (hit & dec.is_lo),
      .wr_hi     (hit & dec.is_hi),
      .clr       (clr_all),
      .wdata     (req_wdata_i),
      .ovf_pulse (ovf_pulse[i]),
      .value     (cnt_val[i])
    );
  end

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (dec.index == 5'(k)) sel_val = cnt_val[k];
    end
  end

  // HI reads return the shadow captured by the preceding LO read, never the live count.
  always_comb begin
    rd_data = '0;
    if (addr_w == CTRL_OFF)         rd_data[CTRL_EN_BIT] = en;
    else if (addr_w == INHIBIT_OFF) rd_data = 32'(inhibit);
    else if (addr_w == OVF_OFF)     rd_data = 32'(ovf);
    else if (addr_w == IRQ_EN_OFF)  rd_data = 32'(irq_en);
    else if (dec.is_lo)             rd_data = sel_val[31:0];
    else if (dec.is_hi)             rd_data = 32'(shadow);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en       <= 1'b1;
      inhibit  <= '0;
      ovf      <= '0;
      irq_en   <= '0;
      shadow   <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      irq_o    <= 1'b0;
    end else begin
      rvalid_o <= rd;
      if (rd) begin
        rdata_o <= rd_data;
        if (dec.is_lo) shadow <= sel_val[CNT_W-1:32];
      end
      if (wr && addr_w == CTRL_OFF)    en      <= req_wdata_i[CTRL_EN_BIT];
      if (wr && addr_w == INHIBIT_OFF) inhibit <= req_wdata_i[NUM_CNT-1:0];
      if (wr && addr_w == IRQ_EN_OFF)  irq_en  <= req_wdata_i[NUM_CNT-1:0];
      // A fresh wrap on a bit survives a same-cycle W1C of that bit.
      if (clr_all) ovf <= '0;
      else         ovf <= (ovf & ~ovf_w1c) | ovf_pulse;
      irq_o <= |(ovf & irq_en);
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Table-driven and scoreboarded bench for perf_counter_bank (NUM_CNT=8, CNT_W=64).
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  evt = '0;
  logic        halt = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] exp; string name; } sb_t;
  sb_t sb [$];

  typedef struct { logic [7:0] addr; logic [31:0] exp; string name; } vec_t;
  vec_t rst_tbl [6];
  vec_t keep_tbl [5];

  perf_counter_bank #(.NUM_CNT(8), .CNT_W(64), .ADDR_W(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .evt_i       (evt),
    .halt_i      (halt),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Read responses are popped from the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_rvalid: rvalid_o=1 with no read outstanding, rdata_o=%h", rdata);
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (rdata !== e.exp) begin
          errors++;
          $display("FAIL %s: rdata_o=%h expected %h", e.name, rdata, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mmio_wr(input logic [7:0] addr, input logic [31:0] data);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic mmio_rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
    sb_t e;
    e.exp = exp; e.name = name;
    sb.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk({name, "_rvalid_seen"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    rst_tbl[0] = '{8'h00, 32'h0000_0001, "ctrl_rst"};
    rst_tbl[1] = '{8'h04, 32'h0000_0000, "inhibit_rst"};
    rst_tbl[2] = '{8'h08, 32'h0000_0000, "ovf_rst"};
    rst_tbl[3] = '{8'h0C, 32'h0000_0000, "irq_en_rst"};
    rst_tbl[4] = '{8'h10, 32'h0000_0000, "cnt0_lo_rst"};
    rst_tbl[5] = '{8'h14, 32'h0000_0000, "cnt0_hi_rst"};

    // Reset with a read request in the final reset cycle: it must be dropped.
    tick(3);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("rvalid_after_rst", 32'(rvalid), 32'd0);
    chk("rdata_after_rst",  rdata, 32'd0);
    chk("irq_after_rst",    32'(irq), 32'd0);
    tick(1);
    chk("rvalid_idle", 32'(rvalid), 32'd0);

    for (int i = 0; i < 6; i++) mmio_rd(rst_tbl[i].addr, rst_tbl[i].exp, rst_tbl[i].name);

    // Ten cycle-counter events.
    evt = 8'h01; tick(10); evt = 8'h00;
    mmio_rd(8'h10, 32'd10, "cnt0_lo_10");
    mmio_rd(8'h18, 32'd0,  "cnt1_lo_0");

    // Counter 2 carries from LO into HI without a full-width wrap.
    mmio_wr(8'h24, 32'h0);
    mmio_wr(8'h20, 32'hFFFF_FFFE);
    evt = 8'h04; tick(2); evt = 8'h00;
    mmio_rd(8'h20, 32'h0, "cnt2_lo_carry");
    mmio_rd(8'h24, 32'h1, "cnt2_hi_carry");
    mmio_rd(8'h08, 32'h0, "ovf_no_wrap");

    // Full-width wrap raises OVF[2] and, one cycle later, irq_o.
    mmio_wr(8'h0C, 32'h4);
    mmio_wr(8'h24, 32'hFFFF_FFFF);
    mmio_wr(8'h20, 32'hFFFF_FFFF);
    mmio_rd(8'h08, 32'h0, "ovf_after_cnt_write");
    evt = 8'h04; tick(1); evt = 8'h00;
    chk("irq_same_cycle", 32'(irq), 32'd0);
    tick(1);
    chk("irq_raised", 32'(irq), 32'd1);
    mmio_rd(8'h08, 32'h4, "ovf_wrap");
    mmio_rd(8'h20, 32'h0, "cnt2_lo_wrap");
    mmio_rd(8'h24, 32'h0, "cnt2_hi_wrap");
    mmio_wr(8'h08, 32'h4);
    tick(1);
    chk("irq_cleared", 32'(irq), 32'd0);
    mmio_rd(8'h08, 32'h0, "ovf_w1c");

    // Tear-free read while counter 3 is counting across the LO->HI carry.
    mmio_wr(8'h2C, 32'h1);
    evt = 8'h08;
    mmio_wr(8'h28, 32'hFFFF_FFFF);
    mmio_rd(8'h28, 32'hFFFF_FFFF, "cnt3_lo_snapshot");
    mmio_rd(8'h2C, 32'h1, "cnt3_hi_shadow");
    evt = 8'h00;

    // Inhibit, halt and global disable.
    mmio_wr(8'h04, 32'h2);
    evt = 8'h03; tick(5); evt = 8'h00;
    mmio_rd(8'h10, 32'd15, "cnt0_inhibit_run");
    mmio_rd(8'h18, 32'd0,  "cnt1_inhibited");
    halt = 1'b1; evt = 8'h03; tick(5); evt = 8'h00; halt = 1'b0;
    mmio_rd(8'h10, 32'd15, "cnt0_halted");
    mmio_rd(8'h18, 32'd0,  "cnt1_halted");
    mmio_wr(8'h00, 32'h0);
    evt = 8'h01; tick(3); evt = 8'h00;
    mmio_rd(8'h00, 32'h0,  "ctrl_disabled");
    mmio_rd(8'h10, 32'd15, "cnt0_disabled");
    mmio_wr(8'h00, 32'h1);

    // Write beats a same-cycle increment; CLR_ALL beats an increment.
    evt = 8'h10;
    mmio_wr(8'h30, 32'd100);
    evt = 8'h00;
    mmio_rd(8'h30, 32'd100, "cnt4_write_wins");
    mmio_wr(8'h3C, 32'hFFFF_FFFF);
    mmio_wr(8'h38, 32'hFFFF_FFFF);
    evt = 8'h20; tick(1); evt = 8'h00;
    mmio_rd(8'h08, 32'h20, "ovf5_wrap");
    evt = 8'h10;
    mmio_wr(8'h00, 32'h3);
    evt = 8'h00;
    mmio_rd(8'h30, 32'd0, "cnt4_clr_wins");
    mmio_rd(8'h10, 32'd0, "cnt0_clr");
    mmio_rd(8'h08, 32'h0, "ovf_clr");
    mmio_rd(8'h00, 32'h1, "ctrl_clr_reads0");

    // New overflow beats a same-cycle W1C on the same bit.
    mmio_wr(8'h3C, 32'hFFFF_FFFF);
    mmio_wr(8'h38, 32'hFFFF_FFFF);
    evt = 8'h20; tick(1); evt = 8'h00;
    mmio_wr(8'h3C, 32'hFFFF_FFFF);
    mmio_wr(8'h38, 32'hFFFF_FFFF);
    evt = 8'h20;
    mmio_wr(8'h08, 32'h20);
    evt = 8'h00;
    mmio_rd(8'h08, 32'h20, "ovf_set_beats_w1c");

    // Unmapped offset reads 0 and swallows writes.
    mmio_rd(8'hFC, 32'h0, "unmapped_read");
    mmio_wr(8'hFC, 32'hFFFF_FFFF);
    keep_tbl[0] = '{8'h00, 32'h0000_0001, "ctrl_kept"};
    keep_tbl[1] = '{8'h04, 32'h0000_0002, "inhibit_kept"};
    keep_tbl[2] = '{8'h08, 32'h0000_0020, "ovf_kept"};
    keep_tbl[3] = '{8'h0C, 32'h0000_0004, "irq_en_kept"};
    keep_tbl[4] = '{8'h30, 32'h0000_0000, "cnt4_kept"};
    for (int i = 0; i < 5; i++) mmio_rd(keep_tbl[i].addr, keep_tbl[i].exp, keep_tbl[i].name);
    chk("irq_masked", 32'(irq), 32'd0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
